// File: rtl/reg_writeback.sv
// Writeback collector: merges ALU and load results into an in-order FIFO and
// retires one entry per cycle to the register file write port.
module reg_writeback #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic [ADDR_W-1:0]            a_addr,
   input  logic [DATA_W-1:0]            a_data,
   input  logic                         b_valid,
   output logic                         b_ready,
   input  logic [ADDR_W-1:0]            b_addr,
   input  logic [DATA_W-1:0]            b_data,
   output logic                         write,
   output logic [ADDR_W-1:0]            regw_addr,
   output logic [DATA_W-1:0]            regw_data,
   output logic [(2**ADDR_W)-1:0]       busy_mask,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned FREE_W = CNT_W + 1;

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  a_slot;
   logic [FREE_W-1:0] free_slots;
   logic              pop;
   logic              a_enq;
   logic              b_enq;

   // The head pops every nonempty cycle, so its slot is reusable this edge.
   assign pop        = (count != '0);
   assign free_slots = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);

   assign b_ready = (free_slots >= FREE_W'(1));
   assign a_ready = (free_slots >= FREE_W'(2)) ||
                    ((free_slots >= FREE_W'(1)) && !b_valid);

   // Register 0 is accepted but dropped before it takes a slot.
   assign b_enq  = b_valid && b_ready && (b_addr != '0);
   assign a_enq  = a_valid && a_ready && (a_addr != '0);
   assign a_slot = wr_ptr + PTR_W'(b_enq);

   // Entry storage; B lands ahead of A when both enqueue together.
   always_ff @(posedge clock) begin
      if (b_enq) begin
         mem_addr[wr_ptr] <= b_addr;
         mem_data[wr_ptr] <= b_data;
      end
      if (a_enq) begin
         mem_addr[a_slot] <= a_addr;
         mem_data[a_slot] <= a_data;
      end
   end

   // Pointers, occupancy and the registered write port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         write     <= 1'b0;
         regw_addr <= '0;
         regw_data <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(b_enq) + PTR_W'(a_enq);
         count  <= count + CNT_W'(b_enq) + CNT_W'(a_enq) - CNT_W'(pop);
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            write     <= 1'b1;
            regw_addr <= mem_addr[rd_ptr];
            regw_data <= mem_data[rd_ptr];
         end else begin
            write <= 1'b0;
         end
      end
   end

   // Pending mask: every live FIFO entry plus the write currently presented.
   always_comb begin
      logic [PTR_W-1:0] offset;
      busy_mask = '0;
      offset    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - rd_ptr;
         if (CNT_W'(offset) < count) begin
            busy_mask[mem_addr[i]] = 1'b1;
         end
      end
      if (write) begin
         busy_mask[regw_addr] = 1'b1;
      end
      busy_mask[0] = 1'b0;
   end

endmodule
